// File: rtl/hdmi_pkt_pkg.sv
// Shared constants and the BCH ECC step used by the HDMI data-island packetizer.
package hdmi_pkt_pkg;

    localparam int PKT_BYTES       = 31;
    localparam int HDR_BYTES       = 3;
    localparam int SUB_BYTES       = 7;
    localparam int NUM_SUB         = 4;
    localparam int ISLAND_PKT_CLKS = 32;

    localparam logic [7:0] BCH_POLY = 8'h83;

    // One BCH step: feedback is the incoming bit XOR the register LSB.
    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic d);
        return {1'b0, e[7:1]} ^ ((d ^ e[0]) ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_bch_lfsr.sv
// 8-bit BCH parity register: clear-on-first-step, STEP data bits per clock,
// then shifts the frozen parity out LSB first, STEP bits per clock.
module hdmi_bch_lfsr
    import hdmi_pkt_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            step_i,
    input  logic            shift_i,
    input  logic [STEP-1:0] d_i,
    output logic [STEP-1:0] par_o
);

    logic [7:0] e_q, e_d, acc;

    always_comb begin
        acc = clr_i ? 8'h00 : e_q;
        for (int s = 0; s < STEP; s++) begin
            acc = bch_step(acc, d_i[s]);
        end
        e_d = e_q;
        if (step_i) begin
            e_d = acc;
        end else if (shift_i) begin
            e_d = e_q >> STEP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e_q <= 8'h00;
        end else begin
            e_q <= e_d;
        end
    end

    assign par_o = e_q[STEP-1:0];

endmodule

// File: rtl/hdmi_island_packetizer.sv
// Produces TERC4 nibbles for the three TMDS channels across the 64-clock data
// island: two packets from double-buffered storage (or null), with BCH parity.
module hdmi_island_packetizer
    import hdmi_pkt_pkg::*;
#(
    parameter int PKT_START = 751,
    parameter int PIPE_LAT  = 2
) (
    input  logic        clkin,
    input  logic        rstin_n,
    input  logic [11:0] counterX,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        wr_en,
    input  logic        wr_slot,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [1:0]  slot_valid,
    input  logic        commit,
    output logic        commit_pending,
    output logic [3:0]  oCh0Data,
    output logic [3:0]  oCh1Data,
    output logic [3:0]  oCh2Data
);

    localparam logic [11:0] WIN_FIRST = 12'(PKT_START);
    localparam logic [11:0] WIN_LAST  = 12'(PKT_START + 2*ISLAND_PKT_CLKS - 1);
    localparam logic [4:0]  HDR_CLKS  = 5'(HDR_BYTES*8);
    localparam logic [4:0]  SUB_CLKS  = 5'(SUB_BYTES*4);

    logic [7:0] sh_q  [2][PKT_BYTES];
    logic [7:0] act_q [2][PKT_BYTES];
    logic [1:0] smask_q, amask_q;
    logic       pending_q;
    logic       copy;

    // Publishing only at counterX==0 keeps the active packets stable across an island.
    assign copy = pending_q && (counterX == 12'd0);

    always_ff @(posedge clkin or negedge rstin_n) begin
        if (!rstin_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int b = 0; b < PKT_BYTES; b++) begin
                    sh_q[s][b]  <= 8'h00;
                    act_q[s][b] <= 8'h00;
                end
            end
            smask_q   <= 2'b00;
            amask_q   <= 2'b00;
            pending_q <= 1'b0;
        end else begin
            if (copy) begin
                act_q   <= sh_q;
                amask_q <= smask_q;
            end
            if (wr_en && (wr_addr != 5'd31)) begin
                sh_q[wr_slot][wr_addr] <= wr_data;
            end
            if (commit && !pending_q) begin
                smask_q   <= slot_valid;
                pending_q <= 1'b1;
            end else if (copy) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign commit_pending = pending_q;

    logic [5:0] p_q;
    logic       win_q, hs_q, vs_q;

    always_ff @(posedge clkin or negedge rstin_n) begin
        if (!rstin_n) begin
            p_q   <= 6'd0;
            win_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            p_q   <= 6'(counterX - WIN_FIRST);
            win_q <= (counterX >= WIN_FIRST) && (counterX <= WIN_LAST);
            hs_q  <= hsync;
            vs_q  <= vsync;
        end
    end

    logic       pkt;
    logic [4:0] k;
    logic [7:0] hdr_byte;
    logic [0:0] hdr_bit, hdr_par;
    logic       hdr_d2;

    assign pkt      = p_q[5];
    assign k        = p_q[4:0];
    assign hdr_byte = act_q[pkt][{3'b000, k[4:3]}];
    assign hdr_bit  = amask_q[pkt] & hdr_byte[k[2:0]];
    assign hdr_d2   = (k < HDR_CLKS) ? hdr_bit[0] : hdr_par[0];

    hdmi_bch_lfsr #(.STEP(1)) u_hdr_ecc (
        .clk_i   (clkin),
        .rst_ni  (rstin_n),
        .clr_i   (k == 5'd0),
        .step_i  (win_q && (k < HDR_CLKS)),
        .shift_i (win_q && (k >= HDR_CLKS)),
        .d_i     (hdr_bit),
        .par_o   (hdr_par)
    );

    logic [NUM_SUB-1:0] ch1_bits, ch2_bits;

    // Subpacket word bits 2k/2k+1 live in byte k/4 at bit offset 2*(k%4).
    for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_sub
        logic [4:0] sub_addr;
        logic [7:0] sub_byte;
        logic [1:0] sub_bits, sub_par;

        assign sub_addr = 5'(HDR_BYTES + SUB_BYTES*gi) + {2'b00, k[4:2]};
        assign sub_byte = (k[4:2] == 3'd7) ? 8'h00 : act_q[pkt][sub_addr];
        assign sub_bits = amask_q[pkt] ? sub_byte[{k[1:0], 1'b0} +: 2] : 2'b00;

        hdmi_bch_lfsr #(.STEP(2)) u_sub_ecc (
            .clk_i   (clkin),
            .rst_ni  (rstin_n),
            .clr_i   (k == 5'd0),
            .step_i  (win_q && (k < SUB_CLKS)),
            .shift_i (win_q && (k >= SUB_CLKS)),
            .d_i     (sub_bits),
            .par_o   (sub_par)
        );

        assign ch1_bits[gi] = (k < SUB_CLKS) ? sub_bits[0] : sub_par[0];
        assign ch2_bits[gi] = (k < SUB_CLKS) ? sub_bits[1] : sub_par[1];
    end

    logic [11:0] out_d;

    always_comb begin
        out_d = {8'h00, 2'b00, vs_q, hs_q};
        if (win_q) begin
            out_d = {ch2_bits, ch1_bits, (k != 5'd0), hdr_d2, vs_q, hs_q};
        end
    end

    logic [11:0] out_q [PIPE_LAT-1];

    for (genvar gi = 0; gi < PIPE_LAT-1; gi++) begin : g_out
        if (gi == 0) begin : g_first
            always_ff @(posedge clkin or negedge rstin_n) begin
                if (!rstin_n) out_q[gi] <= 12'h000;
                else          out_q[gi] <= out_d;
            end
        end else begin : g_rest
            always_ff @(posedge clkin or negedge rstin_n) begin
                if (!rstin_n) out_q[gi] <= 12'h000;
                else          out_q[gi] <= out_q[gi-1];
            end
        end
    end

    assign oCh0Data = out_q[PIPE_LAT-2][3:0];
    assign oCh1Data = out_q[PIPE_LAT-2][7:4];
    assign oCh2Data = out_q[PIPE_LAT-2][11:8];

endmodule

// File: tb/tb_hdmi_island_packetizer.sv
// Bench for hdmi_island_packetizer: packet-level model compared every cycle,
// plus literal expectations on captured island contents.
module tb_hdmi_island_packetizer;

    localparam int WIN_LO = 751;
    localparam int WIN_HI = 814;

    logic        clkin = 1'b0;
    logic        rstin_n = 1'b1;
    logic [11:0] counterX = 12'd0;
    logic        hsync = 1'b0, vsync = 1'b0;
    logic        wr_en = 1'b0, wr_slot = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [7:0]  wr_data = 8'h00;
    logic [1:0]  slot_valid = 2'b00;
    logic        commit = 1'b0;
    logic        commit_pending;
    logic [3:0]  oCh0Data, oCh1Data, oCh2Data;

    always #5 clkin = ~clkin;

    hdmi_island_packetizer dut (
        .clkin          (clkin),
        .rstin_n        (rstin_n),
        .counterX       (counterX),
        .hsync          (hsync),
        .vsync          (vsync),
        .wr_en          (wr_en),
        .wr_slot        (wr_slot),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .slot_valid     (slot_valid),
        .commit         (commit),
        .commit_pending (commit_pending),
        .oCh0Data       (oCh0Data),
        .oCh1Data       (oCh1Data),
        .oCh2Data       (oCh2Data)
    );

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    logic [7:0]  sh_m  [2][31];
    logic [7:0]  act_m [2][31];
    logic [1:0]  smask_m, amask_m;
    logic        pend_m, m_copy;
    logic [11:0] exp1, exp2;
    int          tag1, tag2;

    function automatic logic [7:0] m_step(input logic [7:0] e, input logic d);
        logic f;
        f = d ^ e[0];
        return (e >> 1) ^ (f ? 8'h83 : 8'h00);
    endfunction

    function automatic logic [7:0] m_par(input logic [63:0] bits, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int b = 0; b < n; b++) e = m_step(e, bits[b]);
        return e;
    endfunction

    function automatic logic [7:0] m_byte(input int pkt, input int a);
        return amask_m[pkt] ? act_m[pkt][a] : 8'h00;
    endfunction

    function automatic logic [11:0] m_out(input int cx, input logic hs, input logic vs);
        logic [11:0] o;
        logic [31:0] hw;
        logic [63:0] w;
        int p, pkt, k;
        o = {8'h00, 2'b00, vs, hs};
        if (cx >= WIN_LO && cx <= WIN_HI) begin
            p   = cx - WIN_LO;
            pkt = p / 32;
            k   = p % 32;
            hw[23:0]  = {m_byte(pkt, 2), m_byte(pkt, 1), m_byte(pkt, 0)};
            hw[31:24] = m_par({40'h0, hw[23:0]}, 24);
            o[3:0] = {(k != 0), hw[k], vs, hs};
            for (int i = 0; i < 4; i++) begin
                w = 64'h0;
                for (int j = 0; j < 7; j++) w[8*j +: 8] = m_byte(pkt, 3 + 7*i + j);
                w[63:56] = m_par(w, 56);
                o[4+i] = w[2*k];
                o[8+i] = w[2*k+1];
            end
        end
        return o;
    endfunction

    assign m_copy = pend_m && (counterX == 12'd0);

    always @(posedge clkin or negedge rstin_n) begin
        if (!rstin_n) begin
            exp1 <= 12'h0; exp2 <= 12'h0; tag1 <= -1; tag2 <= -1;
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 31; b++) begin
                    sh_m[s][b]  <= 8'h00;
                    act_m[s][b] <= 8'h00;
                end
            smask_m <= 2'b00; amask_m <= 2'b00; pend_m <= 1'b0;
        end else begin
            exp2 <= exp1;
            exp1 <= m_out(int'(counterX), hsync, vsync);
            tag2 <= tag1;
            tag1 <= int'(counterX);
            if (m_copy) begin
                act_m   <= sh_m;
                amask_m <= smask_m;
            end
            if (wr_en && wr_addr != 5'd31) sh_m[wr_slot][wr_addr] <= wr_data;
            if (commit && !pend_m) begin
                smask_m <= slot_valid;
                pend_m  <= 1'b1;
            end else if (m_copy) begin
                pend_m <= 1'b0;
            end
        end
    end

    // ---------------- compare ----------------
    logic [3:0] cap0 [64];
    logic [3:0] cap1 [64];
    logic [3:0] cap2 [64];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clkin);
            if (chk_en) begin
                chk("ch0", {4'h0, oCh0Data}, {4'h0, exp2[3:0]});
                chk("ch1", {4'h0, oCh1Data}, {4'h0, exp2[7:4]});
                chk("ch2", {4'h0, oCh2Data}, {4'h0, exp2[11:8]});
                chk("pending", {7'h0, commit_pending}, {7'h0, pend_m});
                if (tag2 >= WIN_LO && tag2 <= WIN_HI) begin
                    cap0[tag2 - WIN_LO] = oCh0Data;
                    cap1[tag2 - WIN_LO] = oCh1Data;
                    cap2[tag2 - WIN_LO] = oCh2Data;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int cx);
        counterX = 12'(cx);
        hsync    = counterX[2];
        vsync    = counterX[4];
        @(posedge clkin);
        #1;
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic run_line(input int from, input int to);
        for (int x = from; x <= to; x++) tick(x);
    endtask

    task automatic set_wr(input logic s, input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_slot = s; wr_addr = a; wr_data = d;
    endtask

    task automatic set_commit(input logic [1:0] v);
        commit = 1'b1; slot_valid = v;
    endtask

    logic [7:0] par_byte;

    initial begin
        #1 rstin_n = 1'b0;
        chk_en = 1'b1;
        // Model pins
        chk("model_step0", m_step(8'h00, 1'b1), 8'h83);
        chk("model_step1", m_step(8'h83, 1'b0), 8'hC2);
        chk("model_hdr_par", m_par(64'h1, 24), 8'h4A);
        chk("rst_out", {oCh2Data, oCh1Data}, 8'h00);
        chk("rst_ch0", {4'h0, oCh0Data}, 8'h00);
        repeat (3) @(posedge clkin);
        #1 rstin_n = 1'b1;

        // Line 1: nothing committed, null packets
        run_line(0, 1000);
        chk("null_d3_p0", {7'h0, cap0[0][3]}, 8'h00);
        chk("null_d3_p1", {7'h0, cap0[1][3]}, 8'h01);
        chk("null_d3_p32", {7'h0, cap0[32][3]}, 8'h00);
        chk("null_d2_p5", {7'h0, cap0[5][2]}, 8'h00);

        // Line 2: HB0=0x01 in slot0, commit at 900
        run_line(0, 99);
        set_wr(1'b0, 5'd0, 8'h01);
        run_line(100, 899);
        set_commit(2'b01);
        run_line(900, 1000);

        // Line 3: header with ECC 0x4A; stage slot1 subpacket2 byte0=0x03
        run_line(0, 99);
        set_wr(1'b1, 5'd17, 8'h03);
        run_line(100, 899);
        set_commit(2'b11);
        run_line(900, 1000);
        for (int b = 0; b < 8; b++) par_byte[b] = cap0[24+b][2];
        chk("hdr_parity", par_byte, 8'h4A);
        chk("hdr_k0", {7'h0, cap0[0][2]}, 8'h01);
        chk("hdr_k1", {7'h0, cap0[1][2]}, 8'h00);
        for (int b = 0; b < 8; b++) par_byte[b] = cap0[56+b][2];
        chk("pkt2_null_par", par_byte, 8'h00);

        // Line 4: subpacket data; mid-island commit of HB1=0x55
        run_line(0, 699);
        set_wr(1'b0, 5'd1, 8'h55);
        run_line(700, 779);
        set_commit(2'b11);
        tick(780);
        chk("pend_set", {7'h0, commit_pending}, 8'h01);
        run_line(781, 1000);
        chk("sub2_k0_ch1", {7'h0, cap1[32][2]}, 8'h01);
        chk("sub2_k0_ch2", {7'h0, cap2[32][2]}, 8'h01);
        chk("sub2_k1_ch1", {7'h0, cap1[33][2]}, 8'h00);
        chk("sub_other", {7'h0, cap1[32][0]}, 8'h00);
        chk("island_held", {7'h0, cap0[8][2]}, 8'h00);

        // Line 5: copy at counterX==0 publishes HB1
        tick(0);
        chk("pend_clr", {7'h0, commit_pending}, 8'h00);
        run_line(1, 199);
        set_wr(1'b0, 5'd3, 8'hAA);
        run_line(200, 899);
        set_commit(2'b11);
        run_line(900, 1000);
        chk("hb1_b0", {7'h0, cap0[8][2]}, 8'h01);
        chk("hb1_b1", {7'h0, cap0[9][2]}, 8'h00);
        chk("hb1_b2", {7'h0, cap0[10][2]}, 8'h01);

        // Line 6: write collides with copy; active gets 0xAA
        set_wr(1'b0, 5'd3, 8'h5C);
        tick(0);
        run_line(1, 899);
        set_commit(2'b11);
        run_line(900, 1000);
        chk("old_k0_ch1", {7'h0, cap1[0][0]}, 8'h00);
        chk("old_k0_ch2", {7'h0, cap2[0][0]}, 8'h01);
        chk("old_k1_ch2", {7'h0, cap2[1][0]}, 8'h01);

        // Line 7: second commit publishes 0x5C
        run_line(0, 1000);
        chk("new_k0_ch2", {7'h0, cap2[0][0]}, 8'h00);
        chk("new_k1_ch1", {7'h0, cap1[1][0]}, 8'h01);
        chk("new_k1_ch2", {7'h0, cap2[1][0]}, 8'h01);

        // Line 8: reset at p=10
        run_line(0, 761);
        rstin_n = 1'b0;
        #1;
        chk("rst_mid_ch0", {4'h0, oCh0Data}, 8'h00);
        chk("rst_mid_ch12", {oCh2Data, oCh1Data}, 8'h00);
        run_line(762, 763);
        rstin_n = 1'b1;
        run_line(764, 1000);

        // Line 9: everything null after reset
        run_line(0, 1000);
        chk("post_rst_hb0", {7'h0, cap0[0][2]}, 8'h00);
        chk("post_rst_sub", {7'h0, cap1[32][2]}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
